// File: rtl/br_bist_if.sv
// Bank-side bus between the BR self-test engine (master) and the 4x8 register bank (slave).
interface br_bist_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] Dir;
    logic [DATA_W-1:0] Dato_e;
    logic              WE;
    logic              En;
    logic [DATA_W-1:0] Dato_s;

    modport master (
        output Dir,
        output Dato_e,
        output WE,
        output En,
        input  Dato_s
    );

    modport slave (
        input  Dir,
        input  Dato_e,
        input  WE,
        input  En,
        output Dato_s
    );
endinterface

// File: rtl/br_bist.sv
// Self-test initiator for the BR register bank: writes/reads a true then an inverted
// address-derived pattern and reports pass/fail with details of the first mismatch.
module br_bist #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       ADDR_W = 2,
    parameter int unsigned       DEPTH  = 4,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(10),
    parameter logic [DATA_W-1:0] STEP   = DATA_W'(10)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    br_bist_if.master         bank
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t            state;
    logic              pidx;
    logic [ADDR_W-1:0] dir;
    logic [DATA_W-1:0] dato_e;
    logic              we;
    logic              en;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_vld_q;
    logic [DATA_W-1:0] exp_c;
    logic              mismatch_c;

    // Word for address a in the given pass; pass 1 is the bitwise inverse.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] p;
        p = SEED + STEP * DATA_W'(a);
        return inv ? ~p : p;
    endfunction

    assign bank.Dir    = dir;
    assign bank.Dato_e = dato_e;
    assign bank.WE     = we;
    assign bank.En     = en;

    // Read data returns one cycle after issue, so compare against the registered read address.
    always_comb begin
        exp_c      = pattern(rd_addr_q, pidx);
        mismatch_c = rd_vld_q && (bank.Dato_s != exp_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pidx      <= 1'b0;
            dir       <= '0;
            dato_e    <= '0;
            we        <= 1'b0;
            en        <= 1'b0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    en <= 1'b0;
                    we <= 1'b0;
                    if (start) begin
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_exp  <= '0;
                        fail_got  <= '0;
                        busy      <= 1'b1;
                        pidx      <= 1'b0;
                        dir       <= '0;
                        dato_e    <= pattern('0, 1'b0);
                        en        <= 1'b1;
                        we        <= 1'b1;
                        state     <= WR;
                    end
                end
                WR: begin
                    if (dir == LAST_ADDR) begin
                        dir   <= '0;
                        we    <= 1'b0;
                        state <= RD;
                    end else begin
                        dir    <= dir + 1'b1;
                        dato_e <= pattern(dir + 1'b1, pidx);
                    end
                end
                RD: begin
                    rd_addr_q <= dir;
                    rd_vld_q  <= 1'b1;
                    if (mismatch_c) begin
                        fail_addr <= rd_addr_q;
                        fail_exp  <= exp_c;
                        fail_got  <= bank.Dato_s;
                        en        <= 1'b0;
                        dir       <= '0;
                        rd_vld_q  <= 1'b0;
                        pass      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else if (dir == LAST_ADDR) begin
                        en    <= 1'b0;
                        dir   <= '0;
                        state <= DRAIN;
                    end else begin
                        dir <= dir + 1'b1;
                    end
                end
                DRAIN: begin
                    rd_vld_q <= 1'b0;
                    if (mismatch_c) begin
                        fail_addr <= rd_addr_q;
                        fail_exp  <= exp_c;
                        fail_got  <= bank.Dato_s;
                        pass      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else if (!pidx) begin
                        pidx   <= 1'b1;
                        dir    <= '0;
                        dato_e <= pattern('0, 1'b1);
                        en     <= 1'b1;
                        we     <= 1'b1;
                        state  <= WR;
                    end else begin
                        pass  <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
